// File: rtl/snake_speed_ctrl.sv
// snake_speed_ctrl: Avalon-MM write master that reprograms the game-tick
// interval timer whenever the game level changes.
// Each sequence computes the new period from the level, then stops the
// timer, loads both period halves, restarts it in continuous+IRQ mode and
// clears any stale timeout.
// Optional feature macro: SNAKE_SPEED_IRQ_ACK_EN. When it is defined, the
// controller also acknowledges timer timeouts and pulses tick once per
// timeout.
//
//   state | meaning
//   IDLE  | waiting for a level request (or a timer irq when ACK is enabled)
//   CALC  | compute the new period from the latched level
//   STOP  | write control register: stop bit
//   WR_PL | write period low half
//   WR_PH | write period high half; cur_period updated
//   GAP   | one idle bus cycle so the reload-induced stop lands before start
//   START | write control register: START|CONT|ITO
//   CLR   | write status register: clear stale timeout
//   ACK   | write status register to acknowledge a timeout (optional)
module snake_speed_ctrl #(
  parameter logic [31:0] BASE_PERIOD = 32'd2_499_999,
  parameter logic [31:0] STEP        = 32'd125_000,
  parameter logic [31:0] MIN_PERIOD  = 32'd499_999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  level,
  input  logic        level_valid,
  input  logic        tmr_irq,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [15:0] writedata,
  output logic        busy,
  output logic        cfg_done,
  output logic [31:0] cur_period,
  output logic        tick
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] CALC  = 4'd1;
  localparam logic [3:0] STOP  = 4'd2;
  localparam logic [3:0] WR_PL = 4'd3;
  localparam logic [3:0] WR_PH = 4'd4;
  localparam logic [3:0] GAP   = 4'd5;
  localparam logic [3:0] START = 4'd6;
  localparam logic [3:0] CLR   = 4'd7;
`ifdef SNAKE_SPEED_IRQ_ACK_EN
  localparam logic [3:0] ACK   = 4'd8;
`endif

  // Largest product that still leaves the period at or above the floor.
  localparam logic [31:0] SPAN = BASE_PERIOD - MIN_PERIOD;

  logic [3:0]  state_q, state_d;
  logic [3:0]  lvl_q, lvl_d;
  logic        pend_q, pend_d;
  logic [31:0] p_q, p_d;
  logic [31:0] prod;
  logic [2:0]  address_q, address_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [15:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] cur_q, cur_d;

`ifdef SNAKE_SPEED_IRQ_ACK_EN
  logic        ign_q, ign_d;
  logic        tick_q, tick_d;
`endif

  // Next-state decode; level requests always win over a pending irq.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (level_valid || pend_q) begin
          state_d = CALC;
        end
`ifdef SNAKE_SPEED_IRQ_ACK_EN
        else if (tmr_irq && !ign_q) begin
          state_d = ACK;
        end
`endif
      end
      CALC:  state_d = STOP;
      STOP:  state_d = WR_PL;
      WR_PL: state_d = WR_PH;
      WR_PH: state_d = GAP;
      GAP:   state_d = START;
      START: state_d = CLR;
      CLR:   state_d = (level_valid || pend_q) ? CALC : IDLE;
`ifdef SNAKE_SPEED_IRQ_ACK_EN
      ACK:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Request latch: a strobe in IDLE/CLR is consumed directly, otherwise it
  // is parked as pending with the latest level overwriting older ones.
  always_comb begin
    lvl_d  = lvl_q;
    pend_d = pend_q;
    if (state_q == IDLE || state_q == CLR) begin
      pend_d = 1'b0;
      if (level_valid) begin
        lvl_d = level;
      end
    end else if (level_valid) begin
      pend_d = 1'b1;
      lvl_d  = level;
    end
  end

  // Period computation with saturation at the floor.
  always_comb begin
    prod = {28'd0, lvl_q} * STEP;
    p_d  = p_q;
    if (state_q == CALC) begin
      p_d = (prod > SPAN) ? MIN_PERIOD : (BASE_PERIOD - prod);
    end
  end

  // Registered bus/status outputs are derived from the state being entered.
  always_comb begin
    cs_d      = 1'b0;
    wn_d      = 1'b1;
    address_d = address_q;
    data_d    = data_q;
    case (state_d)
      STOP:  begin cs_d = 1'b1; wn_d = 1'b0; address_d = 3'd1; data_d = 16'h0008;   end
      WR_PL: begin cs_d = 1'b1; wn_d = 1'b0; address_d = 3'd2; data_d = p_q[15:0];  end
      WR_PH: begin cs_d = 1'b1; wn_d = 1'b0; address_d = 3'd3; data_d = p_q[31:16]; end
      START: begin cs_d = 1'b1; wn_d = 1'b0; address_d = 3'd1; data_d = 16'h0007;   end
      CLR:   begin cs_d = 1'b1; wn_d = 1'b0; address_d = 3'd0; data_d = 16'h0000;   end
`ifdef SNAKE_SPEED_IRQ_ACK_EN
      ACK:   begin cs_d = 1'b1; wn_d = 1'b0; address_d = 3'd0; data_d = 16'h0000;   end
`endif
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == CLR);
    cur_d  = (state_d == WR_PH) ? p_q : cur_q;
  end

`ifdef SNAKE_SPEED_IRQ_ACK_EN
  // Tick marks the acknowledge write; the following IDLE cycle ignores the
  // irq line because the timer drops it one cycle after the status write.
  always_comb begin
    tick_d = (state_d == ACK);
    ign_d  = (state_q == ACK);
  end

  // Acknowledge bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= 1'b0;
      ign_q  <= 1'b0;
    end else begin
      tick_q <= tick_d;
      ign_q  <= ign_d;
    end
  end

  assign tick = tick_q;
`else
  logic unused_tmr_irq;
  assign unused_tmr_irq = tmr_irq;
  assign tick = 1'b0;
`endif

  // Main state, request and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lvl_q     <= 4'd0;
      pend_q    <= 1'b0;
      p_q       <= BASE_PERIOD;
      address_q <= 3'd0;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      data_q    <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cur_q     <= BASE_PERIOD;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      pend_q    <= pend_d;
      p_q       <= p_d;
      address_q <= address_d;
      cs_q      <= cs_d;
      wn_q      <= wn_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cur_q     <= cur_d;
    end
  end

  assign address    = address_q;
  assign chipselect = cs_q;
  assign write_n    = wn_q;
  assign writedata  = data_q;
  assign busy       = busy_q;
  assign cfg_done   = done_q;
  assign cur_period = cur_q;

endmodule
